// File: rtl/dequant_pkg.sv
// Shared constants, types and rounding helper for the FP32 dequantizer stream.
package dequant_pkg;

    localparam int          LATENCY = 5;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] ONE     = 32'h3F80_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } lane_result_t;

    // Result class decided before the final normalise/round stage.
    typedef enum logic [2:0] {
        K_PASS,
        K_NORM,
        K_ZERO,
        K_INF,
        K_NAN
    } kind_e;

    function automatic logic round_up(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/dequant_lane.sv
// One dequantizer lane: signed int -> FP32 (RNE), optionally scaled by an FP32 step.
module dequant_lane
    import dequant_pkg::*;
#(
    parameter int LEVEL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEVEL_W-1:0] level,
    input  logic               is_weight,
    input  logic [31:0]        step,
    output lane_result_t       result
);

    localparam int MW = LEVEL_W + 25;

    logic [LEVEL_W-1:0] s1_level;
    logic               s1_w;
    logic [31:0]        s1_step;

    logic               s2_sign, s2_zero, s2_w, s2_guard, s2_sticky;
    logic [7:0]         s2_exp;
    logic [22:0]        s2_frac;
    logic [31:0]        s2_step;

    logic               s3_sign, s3_zero, s3_w;
    logic [7:0]         s3_exp;
    logic [22:0]        s3_frac;
    logic [31:0]        s3_step;

    kind_e              s4_kind;
    logic               s4_sign;
    logic signed [10:0] s4_exp;
    logic [47:0]        s4_prod;
    logic [31:0]        s4_bypass;

    // Normalise the magnitude so its leading one lands on the top bit of norm.
    logic [LEVEL_W-1:0] mag;
    logic [7:0]         msb;
    logic [MW-1:0]      norm;

    always_comb begin
        mag = s1_level[LEVEL_W-1] ? -s1_level : s1_level;
        msb = '0;
        for (int i = 0; i < LEVEL_W; i++) begin
            if (mag[i]) msb = 8'(i);
        end
        norm = {mag, 25'b0} << (8'(LEVEL_W - 1) - msb);
    end

    // A carry out of the fraction propagates straight into the exponent field.
    logic [30:0] s2_rounded;
    assign s2_rounded = {s2_exp, s2_frac} + 31'(round_up(s2_frac[0], s2_guard, s2_sticky));

    logic [7:0]  step_exp;
    logic        step_nan, step_inf, step_zero;
    logic [31:0] level_fp;
    kind_e       kind4;

    always_comb begin
        step_exp  = s3_step[30:23];
        step_nan  = (step_exp == 8'hFF) && (s3_step[22:0] != '0);
        step_inf  = (step_exp == 8'hFF) && (s3_step[22:0] == '0);
        step_zero = (step_exp == 8'h00);
        level_fp  = s3_zero ? '0 : {s3_sign, s3_exp, s3_frac};
        if (!s3_w)                       kind4 = K_PASS;
        else if (step_nan)               kind4 = K_NAN;
        else if (step_inf)               kind4 = s3_zero ? K_NAN : K_INF;
        else if (s3_zero || step_zero)   kind4 = K_ZERO;
        else                             kind4 = K_NORM;
    end

    logic signed [10:0] e_pre, e_fin;
    logic [22:0]        f_pre, f_fin;
    logic               g5, st5;
    lane_result_t       res_next;

    always_comb begin
        if (s4_prod[47]) begin
            e_pre = s4_exp + 11'sd1;
            f_pre = s4_prod[46:24];
            g5    = s4_prod[23];
            st5   = |s4_prod[22:0];
        end else begin
            e_pre = s4_exp;
            f_pre = s4_prod[45:23];
            g5    = s4_prod[22];
            st5   = |s4_prod[21:0];
        end
        {e_fin, f_fin} = {e_pre, f_pre} + 34'(round_up(f_pre[0], g5, st5));
        res_next = '0;
        unique case (s4_kind)
            K_PASS:  res_next = s4_bypass;
            K_ZERO:  res_next = {s4_sign, 31'b0};
            K_INF:   res_next = {s4_sign, 8'hFF, 23'b0};
            K_NAN:   res_next = QNAN;
            default: begin
                // Products that end up subnormal flush to signed zero.
                if (e_fin >= 11'sd255)    res_next = {s4_sign, 8'hFF, 23'b0};
                else if (e_fin <= 11'sd0) res_next = {s4_sign, 31'b0};
                else                      res_next = {s4_sign, e_fin[7:0], f_fin};
            end
        endcase
    end

    // NOTE: data registers are reset too, so weight_fp reads zero out of reset and
    // no stale lane state can leak into the first beats after a mid-stream reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_level  <= '0;
            s1_w      <= 1'b0;
            s1_step   <= '0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b1;
            s2_w      <= 1'b0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_exp    <= '0;
            s2_frac   <= '0;
            s2_step   <= '0;
            s3_sign   <= 1'b0;
            s3_zero   <= 1'b1;
            s3_w      <= 1'b0;
            s3_exp    <= '0;
            s3_frac   <= '0;
            s3_step   <= '0;
            s4_kind   <= K_PASS;
            s4_sign   <= 1'b0;
            s4_exp    <= '0;
            s4_prod   <= '0;
            s4_bypass <= '0;
            result    <= '0;
        end else if (en) begin
            s1_level  <= level;
            s1_w      <= is_weight;
            s1_step   <= step;
            s2_sign   <= s1_level[LEVEL_W-1];
            s2_zero   <= !norm[MW-1];
            s2_exp    <= 8'd127 + msb;
            s2_frac   <= norm[MW-2 -: 23];
            s2_guard  <= norm[MW-25];
            s2_sticky <= |norm[MW-26:0];
            s2_w      <= s1_w;
            s2_step   <= s1_step;
            s3_sign   <= s2_sign;
            s3_zero   <= s2_zero;
            {s3_exp, s3_frac} <= s2_rounded;
            s3_w      <= s2_w;
            s3_step   <= s2_step;
            s4_kind   <= kind4;
            s4_sign   <= s3_sign ^ s3_step[31];
            s4_exp    <= $signed({3'b000, s3_exp}) + $signed({3'b000, step_exp}) - 11'sd127;
            s4_prod   <= 48'({1'b1, s3_frac}) * 48'({1'b1, s3_step[22:0]});
            s4_bypass <= level_fp;
            result    <= res_next;
        end
    end

endmodule

// File: rtl/dequantizer_stream.sv
// Multi-lane dequantizer stream: valid/ready handshake with a global stall,
// shared step register sampled per beat, and a transferred-beat counter.
module dequantizer_stream
    import dequant_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int LEVEL_W   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_LANES-1:0][LEVEL_W-1:0] level_int,
    input  logic [NUM_LANES-1:0]              is_weight,
    input  logic                              cfg_we,
    input  logic [31:0]                       cfg_step,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_LANES-1:0][31:0]        weight_fp,
    output logic [31:0]                       beat_count
);

    logic [LATENCY-1:0] vld;
    logic [31:0]        step_q;

    assign out_valid = vld[LATENCY-1];
    assign in_ready  = !out_valid || out_ready;

    // Lanes read step_q before this cycle's cfg_we lands, so a write never
    // affects the beat accepted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld        <= '0;
            step_q     <= ONE;
            beat_count <= '0;
        end else begin
            if (in_ready)              vld    <= {vld[LATENCY-2:0], in_valid};
            if (cfg_we)                step_q <= cfg_step;
            if (out_valid && out_ready) beat_count <= beat_count + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_result_t res;

        dequant_lane #(.LEVEL_W(LEVEL_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (in_ready),
            .level     (level_int[g]),
            .is_weight (is_weight[g]),
            .step      (step_q),
            .result    (res)
        );

        assign weight_fp[g] = res;
    end

endmodule

// File: tb/tb_dequantizer_stream.sv
// Directed, table-driven bench for dequantizer_stream with hand-computed FP32 results.
module tb_dequantizer_stream;

    localparam int NL = 8;
    localparam int LW = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [NL-1:0][LW-1:0]  level_int;
    logic [NL-1:0]          is_weight;
    logic                   cfg_we;
    logic [31:0]            cfg_step;
    logic                   out_valid;
    logic                   out_ready;
    logic [NL-1:0][31:0]    weight_fp;
    logic [31:0]            beat_count;

    dequantizer_stream #(.NUM_LANES(NL), .LEVEL_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .level_int  (level_int),
        .is_weight  (is_weight),
        .cfg_we     (cfg_we),
        .cfg_step   (cfg_step),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .weight_fp  (weight_fp),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Exact FP32 encoding of a small non-negative integer (< 2^24).
    function automatic logic [31:0] small_fp(input int n);
        logic [31:0] u;
        int          msb;
        u   = 32'(n);
        msb = 0;
        if (n == 0) return 32'h0;
        for (int i = 0; i < 32; i++) if (u[i]) msb = i;
        return {1'b0, 8'(127 + msb), 23'((u << (23 - msb)) & 32'h007F_FFFF)};
    endfunction

    typedef struct {
        logic [31:0] level;
        logic        w;
        logic [31:0] step;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [18];

    // Issues one beat (inputs already set) and waits for it; reports latency in cycles.
    task automatic send_and_wait(output int lat, output logic [NL-1:0][31:0] res);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 10; c++) begin
            if (out_valid) begin
                lat = c;
                res = weight_fp;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int                  lat, lane, n, sent, got;
    logic [NL-1:0][31:0] res;
    logic                fill_ok, hold;
    logic [31:0]         held;
    logic [31:0]         seq [2];

    initial begin
        vecs[0]  = '{32'd3,        1'b1, 32'h3F80_0000, 32'h4040_0000, "l3_step1"};
        vecs[1]  = '{32'hFFFF_FFFE, 1'b1, 32'h3F00_0000, 32'hBF80_0000, "lm2_half"};
        vecs[2]  = '{32'd0,        1'b1, 32'h3F00_0000, 32'h0000_0000, "l0_half"};
        vecs[3]  = '{32'd16777217, 1'b0, 32'h3F00_0000, 32'h4B80_0000, "tie_even_down"};
        vecs[4]  = '{32'd16777219, 1'b0, 32'h3F00_0000, 32'h4B80_0002, "tie_even_up"};
        vecs[5]  = '{32'h7FFF_FFFF, 1'b0, 32'h3F00_0000, 32'h4F00_0000, "int_max"};
        vecs[6]  = '{32'h8000_0000, 1'b0, 32'h3F00_0000, 32'hCF00_0000, "int_min"};
        vecs[7]  = '{32'd1,        1'b1, 32'h7FC0_0000, 32'h7FC0_0000, "step_nan"};
        vecs[8]  = '{32'd5,        1'b0, 32'h7FC0_0000, 32'h40A0_0000, "unscaled_nan"};
        vecs[9]  = '{32'd0,        1'b1, 32'h7F80_0000, 32'h7FC0_0000, "zero_x_inf"};
        vecs[10] = '{32'hFFFF_FFFB, 1'b1, 32'h7F80_0000, 32'hFF80_0000, "neg_x_inf"};
        vecs[11] = '{32'd2,        1'b1, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow"};
        vecs[12] = '{32'hFFFF_FFFF, 1'b1, 32'h0040_0000, 32'h8000_0000, "subn_step"};
        vecs[13] = '{32'd3,        1'b1, 32'h0080_0000, 32'h0140_0000, "min_normal"};
        vecs[14] = '{32'd7,        1'b1, 32'h3FC0_0000, 32'h4128_0000, "l7_x1p5"};
        vecs[15] = '{32'd3,        1'b1, 32'h3EAA_AAAB, 32'h3F80_0000, "sticky_down"};
        vecs[16] = '{32'd3,        1'b1, 32'h3F80_0001, 32'h4040_0002, "mul_tie_up"};
        vecs[17] = '{32'd4,        1'b1, 32'hBF00_0000, 32'hC000_0000, "neg_step"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        level_int = '0;
        is_weight = '0;
        cfg_we    = 1'b0;
        cfg_step  = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_beat_count", beat_count, 32'd0);
        check("rst_weight_fp0", weight_fp[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table: each record goes into one lane; the other lanes carry unscaled fillers.
        foreach (vecs[i]) begin
            cfg_we   = 1'b1;
            cfg_step = vecs[i].step;
            @(negedge clk);
            cfg_we = 1'b0;
            lane   = i % NL;
            for (int j = 0; j < NL; j++) begin
                level_int[j] = 32'(j + 10);
                is_weight[j] = 1'b0;
            end
            level_int[lane] = vecs[i].level;
            is_weight[lane] = vecs[i].w;
            send_and_wait(lat, res);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd5);
            check(vecs[i].name, res[lane], vecs[i].exp);
            fill_ok = 1'b1;
            for (int j = 0; j < NL; j++) begin
                if (j != lane && res[j] !== small_fp(j + 10)) fill_ok = 1'b0;
            end
            check({vecs[i].name, "_fillers"}, 32'(fill_ok), 32'd1);
        end

        // Step written in the acceptance cycle applies only to the following beat.
        cfg_we   = 1'b1;
        cfg_step = 32'h3F80_0000;
        @(negedge clk);
        level_int[0] = 32'd3;
        is_weight[0] = 1'b1;
        in_valid     = 1'b1;
        cfg_step     = 32'h4000_0000;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        seq[0] = 'x;
        seq[1] = 'x;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                if (n < 2) seq[n] = weight_fp[0];
                n++;
            end
            @(negedge clk);
        end
        check("cfg_race_count", 32'(n), 32'd2);
        check("cfg_race_old_step", seq[0], 32'h4040_0000);
        check("cfg_race_new_step", seq[1], 32'h40C0_0000);

        // Reset with three beats in flight (step is 2.0 at this point).
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_beat_count", beat_count, 32'd0);
        check("midrst_weight_fp0", weight_fp[0], 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midrst_no_stale", 32'(n), 32'd0);
        level_int[0] = 32'd3;
        is_weight[0] = 1'b1;
        send_and_wait(lat, res);
        check("midrst_step_one", res[0], 32'h4040_0000);
        @(negedge clk);
        check("midrst_beat_count_1", beat_count, 32'd1);

        // 20-beat stream with out_ready low for three cycles mid-stream.
        do_reset();
        sent = 0;
        got  = 0;
        hold = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            out_ready = !(cyc >= 8 && cyc < 11);
            if (sent < 20) begin
                in_valid     = 1'b1;
                level_int[0] = 32'(sent + 1);
                level_int[1] = 32'(sent + 100);
                is_weight[0] = 1'b1;
                is_weight[1] = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", weight_fp[0], held);
            end
            hold = out_valid && !out_ready;
            held = weight_fp[0];
            if (out_valid && out_ready) begin
                check($sformatf("stream_l0_%0d", got), weight_fp[0], small_fp(got + 1));
                check($sformatf("stream_l1_%0d", got), weight_fp[1], small_fp(got + 100));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_received", 32'(got), 32'd20);
        check("stream_beat_count", beat_count, 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dequantizer_stream.md
DEQUANTIZER_STREAM -- requirements
Module: dequantizer_stream

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8, meaning number of independent dequantizer lanes.
REQ-002 SHALL have parameter LEVEL_W, default 32, meaning width of the signed two's-complement quantization level per lane.
REQ-003 SHALL have parameter LATENCY, fixed at 5 from the shared package, meaning the input-to-output delay in cycles without backpressure.
REQ-004 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  the input beat is valid for all lanes.
REQ-007 SHALL have port in_ready  output  1  the block accepts a beat this cycle.
REQ-008 SHALL have port level_int  input  NUM_LANES x LEVEL_W  signed level per lane.
REQ-009 SHALL have port is_weight  input  NUM_LANES x 1  per lane: 1 = scale by step, 0 = plain int-to-FP32.
REQ-010 SHALL have port cfg_we  input  1  load cfg_step into the step register.
REQ-011 SHALL have port cfg_step  input  32  FP32 step size, shared by all lanes.
REQ-012 SHALL have port out_valid  output  1  the output beat is valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the output beat.
REQ-014 SHALL have port weight_fp  output  NUM_LANES x 32  FP32 result per lane.
REQ-015 SHALL have port beat_count  output  32  count of output beats transferred (out_valid and out_ready), wrapping at 2^32.

Function
REQ-016 SHALL accept a beat when in_valid and in_ready are both high, and transfer an output when out_valid and out_ready are both high.
REQ-017 SHALL drive in_ready = !out_valid || out_ready; the whole pipeline advances only when in_ready is high (global stall).
REQ-018 SHALL present an accepted beat on out_valid/weight_fp exactly LATENCY cycles after acceptance when out_ready is held high.
REQ-019 SHALL hold weight_fp and out_valid stable while out_valid is high and out_ready is low, with no beat lost or duplicated.
REQ-020 SHALL convert the level to FP32 with round-to-nearest-even; a level of 0 SHALL give 0x00000000.
REQ-021 SHALL, for is_weight=1, output FP32(level) x step, rounded to nearest even.
REQ-022 SHALL flush subnormal products and subnormal step values to signed zero.
REQ-023 SHALL saturate product overflow to signed infinity.
REQ-024 SHALL output canonical NaN 0x7FC00000 when the step is NaN, or when the step is infinity and the level is 0.
REQ-025 SHALL, for is_weight=0, output FP32(level) unscaled, independent of the step.
REQ-026 SHALL capture the step value alongside each beat at acceptance, so a cfg_we write affects only beats accepted on later cycles.
REQ-027 SHALL, on cfg_we in the same cycle as an acceptance, apply the old step to that beat.
REQ-028 SHALL process lanes independently; lanes share only the handshake and the step register.

Reset
REQ-029 SHALL, on rst asserted: out_valid=0, in_ready=1, all pipeline valid bits=0, weight_fp=0, beat_count=0, step=0x3F800000 (1.0).
REQ-030 SHALL, on reset asserted mid-stream, discard all in-flight beats with no output produced for them after deassertion.

Structure
REQ-031 SHALL place LATENCY, FP32 constants (QNAN=0x7FC00000, ONE=0x3F800000) and the lane-result struct in the shared package dequant_pkg.
REQ-032 SHALL instantiate one sub-module per lane, dequant_lane, containing the int-to-FP32 and FP32-multiply pipeline with a shared stall enable.

Verification
REQ-033 SHALL cover: level=3, is_weight=1, step 1.0 -> 0x40400000 exactly 5 cycles after acceptance.
REQ-034 SHALL cover: cfg_step=0x3F000000, then level=-2, is_weight=1 -> 0xBF800000; level=0 -> 0x00000000.
REQ-035 SHALL cover: is_weight=0, level=16777217 -> 0x4B800000 (tie rounds to even); the step value is ignored.
REQ-036 SHALL cover: a stream of 20 beats with out_ready low for 3 cycles mid-stream -> outputs held stable, all 20 results in order, beat_count=20.
REQ-037 SHALL cover: step=0x7FC00000 with is_weight=1 -> 0x7FC00000; a cfg_we write in the acceptance cycle -> that beat uses the old step.
REQ-038 SHALL cover: rst pulsed with 3 beats in flight -> out_valid=0, beat_count=0, step=1.0, and no stale outputs afterwards.
